// File: rtl/traffic_pkg.sv
// Shared types and light codes for the intersection controller.
// Phase encoding matches the 2-bit phase output.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  // Lamp pattern shown by the way that owns the phase.
  function automatic logic [2:0] way_light(input phase_e ph);
    logic [2:0] lt;
    lt = LT_RED;
    unique case (ph)
      PH_GREEN:  lt = LT_GRN;
      PH_YELLOW: lt = LT_YEL;
      default:   lt = LT_RED;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_rr.sv
// Round-robin demand search: first requesting way after
// active_way, the current way searched last.
module rr_next_way
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] demand,
  input  logic [WAY_W-1:0]    active_way,
  output logic [WAY_W-1:0]    next_way,
  output logic                found
);

  logic [WAY_W-1:0] idx;

  // Scan far-to-near so the nearest requester wins.
  always_comb begin
    next_way = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = NUM_WAYS; k >= 1; k--) begin
      idx = WAY_W'((int'(active_way) + k) % NUM_WAYS);
      if (demand[idx]) begin
        next_way = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-way round-robin intersection controller, tick-paced.
// Optional night flashing mode: TRAFFIC_NIGHT_FLASH_EN.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS     = 4,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int CNT_W        = 4,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_WAYS-1:0]   demand,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic                  night,
`endif
  output logic [3*NUM_WAYS-1:0] light,
  output logic [WAY_W-1:0]      active_way,
  output logic [1:0]            phase,
  output logic [CNT_W-1:0]      count
);

  localparam logic [3*NUM_WAYS-1:0] RST_LIGHT =
    {{(NUM_WAYS-1){LT_RED}}, LT_GRN};

  phase_e                phase_q, phase_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3*NUM_WAYS-1:0] light_q, light_d;
  logic [NUM_WAYS-1:0]   others;
  logic [WAY_W-1:0]      rr_way, way_inc;
  logic                  rr_found;

  rr_next_way #(.NUM_WAYS(NUM_WAYS)) u_rr (
    .demand     (demand),
    .active_way (way_q),
    .next_way   (rr_way),
    .found      (rr_found)
  );

  assign way_inc = (way_q == WAY_W'(NUM_WAYS - 1)) ?
                   '0 : way_q + WAY_W'(1);

  // Phase/countdown sequencing and registered light encoding.
  always_comb begin
    phase_d = phase_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    light_d = light_q;
    others  = demand;
    others[way_q] = 1'b0;
    if (tick) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
      if (night) begin
        phase_d = PH_FLASH;
        cnt_d   = '0;
      end else
`endif
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unique case (phase_q)
          PH_GREEN: begin
            if (|others) begin
              phase_d = PH_YELLOW;
              cnt_d   = CNT_W'(YELLOW_TICKS);
            end else begin
              cnt_d = CNT_W'(1);
            end
          end
          PH_YELLOW: begin
            phase_d = PH_ALLRED;
            cnt_d   = CNT_W'(ALLRED_TICKS);
          end
          PH_ALLRED: begin
            way_d   = rr_found ? rr_way : way_inc;
            phase_d = PH_GREEN;
            cnt_d   = CNT_W'(GREEN_TICKS);
          end
          default: begin
            phase_d = PH_ALLRED;
            cnt_d   = CNT_W'(ALLRED_TICKS);
          end
        endcase
      end
      for (int i = 0; i < NUM_WAYS; i++) begin
        light_d[3*i +: 3] = (WAY_W'(i) == way_d) ?
                            way_light(phase_d) : LT_RED;
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      if (phase_d == PH_FLASH) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
          light_d[3*i +: 3] =
            (phase_q == PH_FLASH && light_q[1]) ? LT_OFF : LT_YEL;
        end
      end
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      way_q   <= '0;
      cnt_q   <= CNT_W'(GREEN_TICKS);
      light_q <= RST_LIGHT;
    end else begin
      phase_q <= phase_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
    end
  end

  assign light      = light_q;
  assign active_way = way_q;
  assign phase      = phase_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: scoreboard against a
// behavioural model, plus 2- and 8-way safety monitors.
module tb_traffic_intersection_ctrl;

  localparam int NW = 4;

  logic clk, rst, tick, night_r;
  logic [NW-1:0] demand;
  logic [3*NW-1:0] light;
  logic [1:0] active_way, phase;
  logic [3:0] count;

  logic tick2, tick8;
  logic [1:0] dem2;
  logic [7:0] dem8;
  logic [5:0] light2;
  logic [23:0] light8;
  logic aw2;
  logic [2:0] aw8;
  logic [1:0] ph2, ph8;
  logic [3:0] cnt2, cnt8;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int ph;
    int w;
    int cnt;
    logic [3*NW-1:0] lt;
  } exp_t;
  exp_t sb[$];

  int m_ph, m_w, m_cnt;
  bit m_fl;

  traffic_intersection_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .demand(demand),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night_r),
`endif
    .light(light), .active_way(active_way),
    .phase(phase), .count(count)
  );

  traffic_intersection_ctrl #(.NUM_WAYS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick2), .demand(dem2),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(1'b0),
`endif
    .light(light2), .active_way(aw2),
    .phase(ph2), .count(cnt2)
  );

  traffic_intersection_ctrl #(.NUM_WAYS(8)) dut8 (
    .clk(clk), .rst(rst), .tick(tick8), .demand(dem8),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(1'b0),
`endif
    .light(light8), .active_way(aw8),
    .phase(ph8), .count(cnt8)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int non_red(input logic [23:0] l, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (l[3*i +: 3] != 3'b100) c++;
    return c;
  endfunction

  function automatic logic [3*NW-1:0] enc(input int ph, input int w,
                                          input bit fl);
    logic [3*NW-1:0] v;
    for (int i = 0; i < NW; i++) begin
      if (ph == 3) v[3*i +: 3] = fl ? 3'b010 : 3'b000;
      else if (i != w) v[3*i +: 3] = 3'b100;
      else if (ph == 0) v[3*i +: 3] = 3'b001;
      else if (ph == 1) v[3*i +: 3] = 3'b010;
      else v[3*i +: 3] = 3'b100;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_w = 0; m_cnt = 5; m_fl = 0;
  endtask

  task automatic model_tick(input logic [NW-1:0] d, input bit nt);
    logic [NW-1:0] oth;
    int nw;
    if (nt) begin
      m_fl = (m_ph == 3) ? !m_fl : 1'b1;
      m_ph = 3; m_cnt = 0;
    end else if (m_ph == 3) begin
      m_ph = 2; m_cnt = 1;
    end else if (m_cnt > 1) begin
      m_cnt--;
    end else if (m_ph == 0) begin
      oth = d;
      oth[m_w] = 1'b0;
      if (oth != 0) begin m_ph = 1; m_cnt = 2; end
      else m_cnt = 1;
    end else if (m_ph == 1) begin
      m_ph = 2; m_cnt = 1;
    end else begin
      nw = (m_w + 1) % NW;
      for (int k = 1; k <= NW; k++)
        if (d[(m_w + k) % NW]) begin nw = (m_w + k) % NW; break; end
      m_w = nw; m_ph = 0; m_cnt = 5;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ph = m_ph; e.w = m_w; e.cnt = m_cnt;
    e.lt = enc(m_ph, m_w, m_fl);
    sb.push_back(e);
  endtask

  task automatic check_out(input string tg);
    exp_t e;
    e = sb.pop_front();
    chk({tg, ".phase"}, 32'(phase), 32'(e.ph));
    chk({tg, ".way"}, 32'(active_way), 32'(e.w));
    chk({tg, ".count"}, 32'(count), 32'(e.cnt));
    chk({tg, ".light"}, 32'(light), 32'(e.lt));
  endtask

  task automatic step(input string tg, input bit t,
                      input logic [NW-1:0] d, input bit nt);
    tick = t; demand = d; night_r = nt;
    tick2 = 1'($urandom_range(0, 1));
    tick8 = 1'($urandom_range(0, 1));
    dem2 = 2'($urandom);
    dem8 = 8'($urandom);
    if (t) model_tick(d, nt);
    push_exp();
    @(posedge clk);
    #1;
    tick = 0;
    check_out(tg);
  endtask

  task automatic do_reset(input string tg);
    rst = 1; tick = 0; night_r = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    push_exp();
    check_out(tg);
  endtask

  // Safety monitor: at most one non-red way outside night flash.
  always @(negedge clk) begin
    if (!rst) begin
      if (phase != 2'd3) begin
        n_chk++;
        assert ((non_red(24'(light), 4) <= 1) === 1'b1) else begin
          n_fail++;
          $error("FAIL safety4 observed=%0h expected=one_non_red", light);
        end
      end
      n_chk++;
      assert ((non_red(24'(light2), 2) <= 1) === 1'b1) else begin
        n_fail++;
        $error("FAIL safety2 observed=%0h expected=one_non_red", light2);
      end
      n_chk++;
      assert ((non_red(light8, 8) <= 1) === 1'b1) else begin
        n_fail++;
        $error("FAIL safety8 observed=%0h expected=one_non_red", light8);
      end
    end
  end

  initial begin
    rst = 1; tick = 0; demand = '0; night_r = 0;
    tick2 = 0; tick8 = 0; dem2 = '0; dem8 = '0;
    model_reset();
    #12;
    do_reset("reset");

    for (int i = 0; i < 36; i++)
      step("all_dem", (i % 6) != 5, 4'b1111, 0);

    do_reset("reset2");
    for (int i = 0; i < 20; i++)
      step("no_dem", 1, 4'b0000, 0);
    chk("ext_count", 32'(count), 32'd1);
    chk("ext_phase", 32'(phase), 32'd0);

    do_reset("reset3");
    for (int i = 0; i < 24; i++)
      step("skip", 1, 4'b1001, 0);

    do_reset("reset4");
    for (int i = 0; i < 40; i++) begin
      step("to_y2", 1, 4'b1111, 0);
      if (m_ph == 1 && m_w == 2) break;
    end
    chk("y2_phase", 32'(phase), 32'd1);
    chk("y2_way", 32'(active_way), 32'd2);
    #2;
    rst = 1;
    #1;
    model_reset();
    push_exp();
    check_out("async_rst");
    @(posedge clk);
    #1;
    rst = 0;

    do_reset("reset5");
    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 0);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    do_reset("reset6");
    step("fl_g", 1, 4'b1111, 0);
    step("fl_g", 1, 4'b1111, 0);
    step("fl_in", 1, 4'b1111, 1);
    step("fl_off", 1, 4'b1111, 1);
    step("fl_on", 1, 4'b1111, 1);
    step("fl_hold", 0, 4'b1111, 1);
    step("fl_exit", 1, 4'b1111, 0);
    step("fl_next", 1, 4'b1111, 0);
    for (int i = 0; i < 60; i++)
      step("fl_rand", 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 7) == 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
